// File: rtl/fifo_package.sv
// Shared constants and state encoding for the parity checker arbiter.
package fifo_package;

  localparam int DATA_WIDTH      = 8;
  localparam int NUM_REQ_DEF     = 4;
  localparam int CNT_WIDTH_DEF   = 8;
  localparam int TIMEOUT_CYC_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin winner selection: the first asserted request at or above ptr,
// wrapping back to index 0.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt
);

  localparam logic [PTR_W:0] NREQ_W = (PTR_W+1)'(NUM_REQ);

  logic [PTR_W:0] w_idx;
  logic           w_found;

  // Walk the requests starting at ptr and grant the first one found.
  always_comb begin
    gnt     = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = {1'b0, ptr} + (PTR_W+1)'(i);
      if (w_idx >= NREQ_W) begin
        w_idx = w_idx - NREQ_W;
      end
      if (!w_found && req[w_idx[PTR_W-1:0]]) begin
        gnt[w_idx[PTR_W-1:0]] = 1'b1;
        w_found               = 1'b1;
      end
    end
  end

endmodule

// File: rtl/parity_arbiter.sv
// Shares one parity checker between NUM_REQ requesters. One transaction is in
// flight at a time: IDLE grants a requester, ISSUE hands the word to the
// checker, WAIT collects the result (or times out) and reports it back.
module parity_arbiter
  import fifo_package::*;
#(
  parameter int NUM_REQ     = NUM_REQ_DEF,
  parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]              req_grant_o,
  output logic [DATA_WIDTH-1:0]           chk_data_o,
  output logic                            chk_valid_o,
  input  logic                            chk_grant_i,
  input  logic                            res_valid_i,
  input  logic                            res_err_i,
  output logic [NUM_REQ-1:0]              done_o,
  output logic                            err_o,
  output logic                            timeout_o,
  output logic [NUM_REQ*CNT_WIDTH-1:0]    err_cnt_o,
  output logic                            busy_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [PTR_W-1:0]     PTR_LAST = PTR_W'(NUM_REQ - 1);
  localparam logic [TMR_W-1:0]     TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [NUM_REQ-1:0]   OH_ZERO  = NUM_REQ'(1);

  arb_state_e              r_state;
  logic [PTR_W-1:0]        r_ptr;
  logic [PTR_W-1:0]        r_owner;
  logic [TMR_W-1:0]        r_timer;
  logic [CNT_WIDTH-1:0]    r_cnt [NUM_REQ];
  logic [DATA_WIDTH-1:0]   r_chk_data;
  logic                    r_chk_valid;
  logic [NUM_REQ-1:0]      r_done;
  logic                    r_err;
  logic                    r_timeout;

  logic [NUM_REQ-1:0]      w_gnt;
  logic [PTR_W-1:0]        w_win_idx;
  logic [PTR_W-1:0]        w_ptr_next;

  // Error counters stop at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) begin
        idx = idx | PTR_W'(i);
      end
    end
    return idx;
  endfunction

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .req (req_valid_i),
    .ptr (r_ptr),
    .gnt (w_gnt)
  );

  assign w_win_idx  = onehot_to_idx(w_gnt);
  assign w_ptr_next = (w_win_idx == PTR_LAST) ? '0 : w_win_idx + 1'b1;

  // Transaction FSM with registered checker handshake and completion outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_owner     <= '0;
      r_timer     <= '0;
      r_chk_data  <= '0;
      r_chk_valid <= 1'b0;
      r_done      <= '0;
      r_err       <= 1'b0;
      r_timeout   <= 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
        r_cnt[k] <= '0;
      end
    end else begin
      r_done    <= '0;
      r_err     <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (|w_gnt) begin
            r_chk_data  <= req_data_i[int'(w_win_idx)*DATA_WIDTH +: DATA_WIDTH];
            r_chk_valid <= 1'b1;
            r_owner     <= w_win_idx;
            r_ptr       <= w_ptr_next;
            r_state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (r_chk_valid && chk_grant_i) begin
            r_chk_valid <= 1'b0;
            r_timer     <= '0;
            r_state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A result arriving on the expiry cycle takes precedence.
          if (res_valid_i) begin
            r_done  <= OH_ZERO << r_owner;
            r_err   <= res_err_i;
            if (res_err_i) begin
              r_cnt[r_owner] <= sat_inc(r_cnt[r_owner]);
            end
            r_state <= ST_IDLE;
          end else if (r_timer == TMR_LAST) begin
            r_done         <= OH_ZERO << r_owner;
            r_err          <= 1'b1;
            r_timeout      <= 1'b1;
            r_cnt[r_owner] <= sat_inc(r_cnt[r_owner]);
            r_state        <= ST_IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_grant_o = (r_state == ST_IDLE) ? w_gnt : '0;
  assign chk_data_o  = r_chk_data;
  assign chk_valid_o = r_chk_valid;
  assign done_o      = r_done;
  assign err_o       = r_err;
  assign timeout_o   = r_timeout;
  assign busy_o      = (r_state != ST_IDLE);

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_cnt_out
    assign err_cnt_o[k*CNT_WIDTH +: CNT_WIDTH] = r_cnt[k];
  end

endmodule

// File: tb/tb_parity_arbiter.sv
// Randomized and directed bench for parity_arbiter against a transaction-level model.
module tb_parity_arbiter;
  import fifo_package::*;

  localparam int NR = 4;
  localparam int CW = 8;
  localparam int TO = 16;
  localparam int DW = DATA_WIDTH;
  localparam int CMAX = (1 << CW) - 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NR-1:0]        req_valid;
  logic [NR*DW-1:0]     req_data;
  logic [NR-1:0]        req_grant;
  logic [DW-1:0]        chk_data;
  logic                 chk_valid;
  logic                 chk_grant;
  logic                 res_valid;
  logic                 res_err;
  logic [NR-1:0]        done;
  logic                 err;
  logic                 timeout;
  logic [NR*CW-1:0]     err_cnt;
  logic                 busy;

  always #5 clk = ~clk;

  parity_arbiter #(
    .NUM_REQ     (NR),
    .CNT_WIDTH   (CW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_grant_o (req_grant),
    .chk_data_o  (chk_data),
    .chk_valid_o (chk_valid),
    .chk_grant_i (chk_grant),
    .res_valid_i (res_valid),
    .res_err_i   (res_err),
    .done_o      (done),
    .err_o       (err),
    .timeout_o   (timeout),
    .err_cnt_o   (err_cnt),
    .busy_o      (busy)
  );

  int total = 0;
  int bad   = 0;
  int m_ptr;
  int m_cnt [NR];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_ptr = 0;
    for (int k = 0; k < NR; k++) m_cnt[k] = 0;
  endtask

  // Expected winner: first valid requester scanning upward from the pointer.
  function automatic int model_winner(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) begin
      if (v[(m_ptr + i) % NR]) return (m_ptr + i) % NR;
    end
    return -1;
  endfunction

  function automatic logic [NR*CW-1:0] model_cnt_vec();
    logic [NR*CW-1:0] v;
    v = '0;
    for (int k = 0; k < NR; k++) v[k*CW +: CW] = CW'(m_cnt[k]);
    return v;
  endfunction

  // One full transaction: gdly cycles of checker back-pressure, result in WAIT
  // cycle rdly (rdly >= TO means no result, so the timer expires).
  task automatic do_txn(input logic [NR-1:0] vld, input logic [NR*DW-1:0] data,
                        input int gdly, input int rdly, input bit e, output int who);
    int            w;
    int            last;
    bit            tmo;
    logic [DW-1:0] held;
    req_valid = vld;
    req_data  = data;
    chk_grant = 1'b0;
    res_valid = 1'b0;
    res_err   = 1'b0;
    #1;
    w   = model_winner(vld);
    who = w;
    if (w < 0) begin
      chk("idle_no_grant", 64'(req_grant), 64'(0));
      res_valid = 1'b1;
      res_err   = 1'b1;
      step();
      res_valid = 1'b0;
      res_err   = 1'b0;
      chk("idle_res_ignored_done", 64'(done), 64'(0));
      chk("idle_res_ignored_err", 64'(err), 64'(0));
      chk("idle_res_ignored_cnt", 64'(err_cnt), 64'(model_cnt_vec()));
      chk("idle_busy", 64'(busy), 64'(0));
      return;
    end
    chk("grant", 64'(req_grant), 64'(1) << w);
    chk("busy_idle", 64'(busy), 64'(0));
    held = data[w*DW +: DW];
    m_ptr = (w + 1) % NR;
    step();
    for (int i = 0; i <= gdly; i++) begin
      req_valid = NR'($urandom);
      req_data  = (NR*DW)'($urandom);
      chk_grant = (i == gdly);
      #1;
      chk("issue_valid", 64'(chk_valid), 64'(1));
      chk("issue_data", 64'(chk_data), 64'(held));
      chk("issue_no_grant", 64'(req_grant), 64'(0));
      chk("issue_busy", 64'(busy), 64'(1));
      step();
    end
    chk_grant = 1'b0;
    tmo  = (rdly > TO - 1);
    last = tmo ? TO - 1 : rdly;
    for (int i = 0; i <= last; i++) begin
      res_valid = !tmo && (i == rdly);
      res_err   = res_valid ? e : 1'($urandom);
      req_valid = NR'($urandom);
      #1;
      chk("wait_valid_low", 64'(chk_valid), 64'(0));
      chk("wait_no_done", 64'(done), 64'(0));
      chk("wait_no_timeout", 64'(timeout), 64'(0));
      chk("wait_no_grant", 64'(req_grant), 64'(0));
      chk("wait_busy", 64'(busy), 64'(1));
      step();
    end
    res_valid = 1'b0;
    res_err   = 1'b0;
    req_valid = '0;
    if (tmo || e) m_cnt[w] = (m_cnt[w] < CMAX) ? m_cnt[w] + 1 : CMAX;
    chk("done_pulse", 64'(done), 64'(1) << w);
    chk("done_err", 64'(err), 64'(tmo || e));
    chk("done_timeout", 64'(timeout), 64'(tmo));
    chk("done_cnt", 64'(err_cnt), 64'(model_cnt_vec()));
    chk("done_busy", 64'(busy), 64'(0));
    step();
    chk("after_done", 64'(done), 64'(0));
    chk("after_err", 64'(err), 64'(0));
    chk("after_timeout", 64'(timeout), 64'(0));
  endtask

  initial begin
    int who;
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    chk_grant = 1'b0;
    res_valid = 1'b0;
    res_err   = 1'b0;
    model_reset();
    step();
    step();
    chk("rst_chk_valid", 64'(chk_valid), 64'(0));
    chk("rst_chk_data", 64'(chk_data), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_timeout", 64'(timeout), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_cnt", 64'(err_cnt), 64'(0));
    rst = 1'b0;
    step();

    // All requesters valid: strict rotation starting at requester 0.
    for (int t = 0; t < 8; t++) begin
      do_txn(4'hF, (NR*DW)'($urandom), 0, 0, 1'b0, who);
      chk("rr_order", 64'(who), 64'(t % NR));
    end

    // Single request from requester 0 with data 0xA5, clean result.
    do_txn(4'b0001, {8'h11, 8'h22, 8'h33, 8'hA5}, 0, 1, 1'b0, who);
    chk("single_owner", 64'(who), 64'(0));
    chk("single_cnt", 64'(err_cnt), 64'(0));

    // Checker back-pressure for five cycles.
    do_txn(4'b1000, (NR*DW)'($urandom), 5, 2, 1'b0, who);

    // No result: timeout on requester 1.
    do_txn(4'b0010, (NR*DW)'($urandom), 0, TO + 4, 1'b0, who);
    chk("timeout_cnt1", 64'(err_cnt[1*CW +: CW]), 64'(1));

    // Result on the expiry cycle beats the timeout.
    do_txn(4'b0100, (NR*DW)'($urandom), 1, TO - 1, 1'b1, who);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      do_txn(NR'($urandom_range(0, 15)), (NR*DW)'($urandom), int'($urandom_range(0, 3)),
             int'($urandom_range(0, TO + 2)), 1'($urandom), who);
    end

    // Fresh start, then saturate requester 2's counter.
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    chk("rst2_cnt", 64'(err_cnt), 64'(0));
    for (int t = 0; t < 300; t++) begin
      do_txn(4'b0100, (NR*DW)'($urandom), 0, 0, 1'b1, who);
    end
    chk("sat_cnt2", 64'(err_cnt[2*CW +: CW]), 64'(CMAX));
    chk("sat_cnt0", 64'(err_cnt[0*CW +: CW]), 64'(0));
    chk("sat_cnt1", 64'(err_cnt[1*CW +: CW]), 64'(0));
    chk("sat_cnt3", 64'(err_cnt[3*CW +: CW]), 64'(0));

    // Reset while waiting for a result abandons the transaction.
    req_valid = 4'b0100;
    req_data  = (NR*DW)'($urandom);
    #1;
    chk("mid_grant", 64'(req_grant), 64'(4));
    step();
    req_valid = '0;
    chk_grant = 1'b1;
    step();
    chk_grant = 1'b0;
    chk("mid_in_wait", 64'(busy), 64'(1));
    rst       = 1'b1;
    res_valid = 1'b1;
    res_err   = 1'b1;
    step();
    rst       = 1'b0;
    res_valid = 1'b0;
    res_err   = 1'b0;
    model_reset();
    chk("mid_rst_done", 64'(done), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_cnt", 64'(err_cnt), 64'(0));
    step();
    chk("mid_rst_done2", 64'(done), 64'(0));
    do_txn(4'hF, (NR*DW)'($urandom), 0, 0, 1'b0, who);
    chk("post_rst_first", 64'(who), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/parity_arbiter.md
PARITY_ARBITER -- requirements
Module: parity_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing the parity checker.
REQ-002 SHALL have parameter CNT_WIDTH, default 8, width of each per-requester error counter.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 16, maximum number of cycles to wait for a check result.
REQ-004 SHALL take DATA_WIDTH from fifo_package.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset: synchronous and active-high.
REQ-007 SHALL have port req_valid_i, input, NUM_REQ, per-requester request valid.
REQ-008 SHALL have port req_data_i, input, NUM_REQ*DATA_WIDTH, per-requester data; requester k occupies slice [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port req_grant_o, output, NUM_REQ, one-hot acceptance.
REQ-010 SHALL have port chk_data_o, output, DATA_WIDTH, word presented to the parity checker.
REQ-011 SHALL have port chk_valid_o, output, 1, checker valid.
REQ-012 SHALL have port chk_grant_i, input, 1, checker grant.
REQ-013 SHALL have port res_valid_i, input, 1, checker result valid.
REQ-014 SHALL have port res_err_i, input, 1, parity error flag, qualified by res_valid_i.
REQ-015 SHALL have port done_o, output, NUM_REQ, one-cycle completion pulse to the owning requester.
REQ-016 SHALL have port err_o, output, 1, error status, qualified by done_o.
REQ-017 SHALL have port timeout_o, output, 1, one-cycle timeout pulse.
REQ-018 SHALL have port err_cnt_o, output, NUM_REQ*CNT_WIDTH, per-requester error counters.
REQ-019 SHALL have port busy_o, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-020 SHALL implement FSM states IDLE, ISSUE and WAIT; at most one transaction is outstanding.
REQ-021 In IDLE, req_grant_o SHALL be combinational and one-hot on the round-robin winner among the asserted req_valid_i bits, searching from rr_ptr upward with wrap; req_grant_o SHALL be zero in all other states.
REQ-022 On a transfer (req_valid_i[k] and req_grant_o[k]) in cycle T, the block SHALL register the data slice into chk_data_o, record owner=k, set rr_ptr=(k+1) mod NUM_REQ and enter ISSUE, so chk_valid_o is high in T+1.
REQ-023 In ISSUE, chk_valid_o SHALL be 1 and chk_data_o SHALL be held stable until chk_valid_o and chk_grant_i are both high; the block SHALL then enter WAIT and clear the timer.
REQ-024 In WAIT, on res_valid_i the block SHALL, on the next cycle, pulse done_o[owner], drive err_o=res_err_i, increment err_cnt[owner] if res_err_i is set, and return to IDLE.
REQ-025 In WAIT, the timer SHALL increment each cycle; if it reaches TIMEOUT_CYC-1 without res_valid_i, the block SHALL pulse timeout_o and done_o[owner] with err_o=1, increment err_cnt[owner] and return to IDLE.
REQ-026 When res_valid_i and timeout expiry occur in the same cycle, the result SHALL win and timeout_o SHALL remain 0.
REQ-027 res_valid_i outside WAIT SHALL be ignored, with no output effect.
REQ-028 Error counters SHALL saturate at 2^CNT_WIDTH-1.
REQ-029 Back-to-back operation: a new grant SHALL be possible in the cycle after done_o, giving a 4-cycle minimum transaction with immediate chk_grant_i and res_valid_i.
REQ-030 err_o SHALL be 0 whenever done_o is zero.

Reset
REQ-031 While rst is high at a clock edge, the block SHALL enter IDLE and set rr_ptr=0 (requester 0 has highest priority), owner=0, timer=0 and all counters to 0.
REQ-032 Reset values of outputs SHALL be: chk_valid_o=0, chk_data_o=0, done_o=0, err_o=0, timeout_o=0 and busy_o=0.
REQ-033 Reset mid-transaction SHALL abandon the transaction with no done_o pulse and no counter update.

Structure
REQ-034 The FSM state enum and the default constants for NUM_REQ, CNT_WIDTH and TIMEOUT_CYC SHALL live in fifo_package, alongside DATA_WIDTH.
REQ-035 The round-robin winner selection SHALL be a sub-module named rr_arbiter, with inputs req and ptr and output one-hot gnt.

Verification
REQ-036 The bench SHALL cover: single request, req_valid_i=0001, data 0xA5, chk_grant_i immediate, res_valid_i with err 0 two cycles later -> done_o=0001, err_o=0, err_cnt unchanged.
REQ-037 The bench SHALL cover: all requesters held valid for 8 transactions -> grant order 0,1,2,3,0,1,2,3 and no requester starved.
REQ-038 The bench SHALL cover: chk_grant_i low for 5 cycles in ISSUE -> chk_valid_o held high and chk_data_o constant, with no new grant.
REQ-039 The bench SHALL cover: no result within TIMEOUT_CYC -> timeout_o pulse, done_o[owner] with err_o=1, err_cnt[owner] incremented by 1.
REQ-040 The bench SHALL cover: 300 errored transactions on requester 2 -> err_cnt[2]=255 (saturated), other counters 0.
REQ-041 The bench SHALL cover: rst asserted in WAIT -> no done_o pulse, next request from requester 0 granted first.
